// File: rtl/sw_led_pkg.sv
// -----------------------------------------------------------------------------
// sw_led_pkg
// Shared types and constants for the switch-driven RGB LED controller.
//   mode_t   : LED behaviour selected by the debounced switches
//   PWM_W    : width of the PWM counter, duty and duty shadow
//   DUTY_MAX : largest duty value; the breathe ramp turns around here
// -----------------------------------------------------------------------------
package sw_led_pkg;

  localparam int PWM_W = 8;

  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_SOLID   = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Single-bit switch conditioner: two-flop synchronizer followed by a
// stability counter. The output only follows the synchronized input after it
// has disagreed with the output for DB_LIMIT consecutive cycles.
// Ports:
//   clk100  : clock
//   rst     : synchronous active-high reset
//   i_sw    : raw asynchronous switch input
//   o_sw_db : debounced switch state
// -----------------------------------------------------------------------------
module sw_debounce #(
  parameter int DB_LIMIT = 1_000_000
) (
  input  logic clk100,
  input  logic rst,
  input  logic i_sw,
  output logic o_sw_db
);

  localparam int CNT_W = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LIMIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge; r_sync2 <= r_sync1 really is two stages.
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        // Agreement at any point restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sw_db = r_db;

endmodule

// File: rtl/sw_led_ctrl.sv
// -----------------------------------------------------------------------------
// sw_led_ctrl
// Two debounced switches select one of four LED behaviours: off, solid on,
// blink at a fixed half-period, or a triangle "breathe" produced by PWM whose
// duty ramps 0..255..0. All three colour outputs carry the same drive.
// Ports:
//   clk100              : single clock for all logic
//   rst                 : synchronous active-high reset
//   sw_in[1:0]          : raw asynchronous switches
//   led_r, led_g, led_b : registered LED drives
//   sw_db[1:0]          : debounced switch state
//   mode                : current mode, sw_db delayed by one cycle
// -----------------------------------------------------------------------------
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int DB_LIMIT     = 1_000_000,
  parameter int BLINK_HALF   = 50_000_000,
  parameter int BREATHE_STEP = 390_625
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic [1:0] sw_in,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [1:0] sw_db,
  output mode_t      mode
);

  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int STEP_W  = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(BREATHE_STEP - 1);

  // ---------------------------------------------------------------------------
  // Switch conditioning
  // ---------------------------------------------------------------------------
  logic [1:0] w_sw_db;

  for (genvar g = 0; g < 2; g++) begin : g_db
    sw_debounce #(
      .DB_LIMIT(DB_LIMIT)
    ) u_sw_debounce (
      .clk100 (clk100),
      .rst    (rst),
      .i_sw   (sw_in[g]),
      .o_sw_db(w_sw_db[g])
    );
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mode_t              r_mode;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [PWM_W-1:0]   r_pwm_cnt;
  logic [PWM_W-1:0]   r_duty_active;
  logic [STEP_W-1:0]  r_step_cnt;
  logic [PWM_W-1:0]   r_duty;
  logic               r_dir_down;
  logic               r_led;

  mode_t              w_mode_nxt;
  logic               w_mode_chg;
  logic               w_pwm;
  logic [BLINK_W-1:0] w_blink_cnt_nxt;
  logic               w_blink_phase_nxt;
  logic [STEP_W-1:0]  w_step_cnt_nxt;
  logic [PWM_W-1:0]   w_duty_nxt;
  logic               w_dir_down_nxt;
  logic               w_led_nxt;

  // The shadow only reloads at the end of a PWM period, so each period is
  // generated from one consistent duty value.
  assign w_pwm = (r_pwm_cnt < r_duty_active);

  // ---------------------------------------------------------------------------
  // Next-state and LED decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_mode_nxt        = mode_t'(w_sw_db);
    w_mode_chg        = (w_mode_nxt != r_mode);
    w_blink_cnt_nxt   = r_blink_cnt;
    w_blink_phase_nxt = r_blink_phase;
    w_step_cnt_nxt    = r_step_cnt;
    w_duty_nxt        = r_duty;
    w_dir_down_nxt    = r_dir_down;
    w_led_nxt         = 1'b0;

    unique case (r_mode)
      MODE_OFF: begin
        w_led_nxt = 1'b0;
      end
      MODE_SOLID: begin
        w_led_nxt = 1'b1;
      end
      MODE_BLINK: begin
        w_led_nxt = r_blink_phase;
        if (r_blink_cnt == BLINK_LAST) begin
          w_blink_cnt_nxt   = '0;
          w_blink_phase_nxt = ~r_blink_phase;
        end else begin
          w_blink_cnt_nxt = r_blink_cnt + 1'b1;
        end
      end
      MODE_BREATHE: begin
        w_led_nxt = w_pwm;
        if (r_step_cnt == STEP_LAST) begin
          w_step_cnt_nxt = '0;
          // Turn around at the ends instead of wrapping, giving a triangle.
          if (!r_dir_down) begin
            if (r_duty == DUTY_MAX) begin
              w_dir_down_nxt = 1'b1;
              w_duty_nxt     = DUTY_MAX - 1'b1;
            end else begin
              w_duty_nxt = r_duty + 1'b1;
            end
          end else begin
            if (r_duty == '0) begin
              w_dir_down_nxt = 1'b0;
              w_duty_nxt     = PWM_W'(1);
            end else begin
              w_duty_nxt = r_duty - 1'b1;
            end
          end
        end else begin
          w_step_cnt_nxt = r_step_cnt + 1'b1;
        end
      end
      default: begin
        w_led_nxt = 1'b0;
      end
    endcase

    // The edge that loads a new mode also restarts its timing, so every mode
    // is entered from a clean blink/breathe state.
    if (w_mode_chg) begin
      w_blink_cnt_nxt   = '0;
      w_blink_phase_nxt = 1'b0;
      w_step_cnt_nxt    = '0;
      w_duty_nxt        = '0;
      w_dir_down_nxt    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_mode        <= MODE_OFF;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_pwm_cnt     <= '0;
      r_duty_active <= '0;
      r_step_cnt    <= '0;
      r_duty        <= '0;
      r_dir_down    <= 1'b0;
      r_led         <= 1'b0;
    end else begin
      r_mode        <= w_mode_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      r_pwm_cnt     <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == DUTY_MAX) begin
        r_duty_active <= r_duty;
      end
      r_step_cnt    <= w_step_cnt_nxt;
      r_duty        <= w_duty_nxt;
      r_dir_down    <= w_dir_down_nxt;
      r_led         <= w_led_nxt;
    end
  end

  assign led_r = r_led;
  assign led_g = r_led;
  assign led_b = r_led;
  assign sw_db = w_sw_db;
  assign mode  = r_mode;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sw_led_ctrl
// Directed bench for sw_led_ctrl with DB_LIMIT=4, BLINK_HALF=8, BREATHE_STEP=2.
// Inputs change and outputs are sampled on the falling clock edge; "after
// edge N" means the sample taken at the falling edge following rising edge N.
// -----------------------------------------------------------------------------
module tb_sw_led_ctrl;
  import sw_led_pkg::*;

  logic       clk100;
  logic       rst;
  logic [1:0] sw_in;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic [1:0] sw_db;
  mode_t      mode;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;  // rising edges since reset release; equals pwm_cnt mod 256

  sw_led_ctrl #(
    .DB_LIMIT    (4),
    .BLINK_HALF  (8),
    .BREATHE_STEP(2)
  ) dut (
    .clk100(clk100),
    .rst   (rst),
    .sw_in (sw_in),
    .led_r (led_r),
    .led_g (led_g),
    .led_b (led_b),
    .sw_db (sw_db),
    .mode  (mode)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  always @(posedge clk100) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Triangle duty expected after j breathe steps from mode entry (j <= 510).
  function automatic int duty_model(input int j);
    return (j <= 255) ? j : 510 - j;
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk100);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst   = 1'b1;
    sw_in = 2'b11;
    wait_edges(3);
    checks++;
    if ({led_r, led_g, led_b} !== 3'b000) begin
      errors++; $display("FAIL reset_leds: got %b expected 000", {led_r, led_g, led_b});
    end
    checks++;
    if (mode !== MODE_OFF) begin
      errors++; $display("FAIL reset_mode: got %b expected 00", mode);
    end
    checks++;
    if (sw_db !== 2'b00) begin
      errors++; $display("FAIL reset_sw_db: got %b expected 00", sw_db);
    end
    rst = 1'b0;
    wait_edges(5);
    checks++;
    if (sw_db !== 2'b00) begin
      errors++; $display("FAIL reset_db_edge5: got %b expected 00", sw_db);
    end
    wait_edges(1);
    checks++;
    if (sw_db !== 2'b11) begin
      errors++; $display("FAIL reset_db_edge6: got %b expected 11", sw_db);
    end
    wait_edges(1);
    checks++;
    if (mode !== MODE_BREATHE) begin
      errors++; $display("FAIL reset_mode_edge7: got %b expected 11", mode);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_debounce();
    int bad;
    sw_in = 2'b00;
    wait_edges(5);
    checks++;
    if (sw_db !== 2'b11) begin
      errors++; $display("FAIL db_fall_edge5: got %b expected 11", sw_db);
    end
    wait_edges(1);
    checks++;
    if (sw_db !== 2'b00) begin
      errors++; $display("FAIL db_fall_edge6: got %b expected 00", sw_db);
    end
    wait_edges(2);
    sw_in = 2'b01;
    wait_edges(5);
    checks++;
    if (sw_db !== 2'b00) begin
      errors++; $display("FAIL db_rise_edge5: got %b expected 00", sw_db);
    end
    wait_edges(1);
    checks++;
    if (sw_db !== 2'b01) begin
      errors++; $display("FAIL db_rise_edge6: got %b expected 01", sw_db);
    end
    // Three-cycle glitch on both bits must be rejected.
    bad = 0;
    sw_in = 2'b10;
    for (int i = 0; i < 3; i++) begin
      wait_edges(1);
      if (sw_db !== 2'b01) bad++;
    end
    sw_in = 2'b01;
    for (int i = 0; i < 10; i++) begin
      wait_edges(1);
      if (sw_db !== 2'b01) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL db_glitch: got %0d cycles with sw_db != 01, expected 0 (now %b)", bad, sw_db);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_solid();
    checks++;
    if (mode !== MODE_SOLID) begin
      errors++; $display("FAIL solid_mode: got %b expected 01", mode);
    end
    checks++;
    if ({led_r, led_g, led_b} !== 3'b111) begin
      errors++; $display("FAIL solid_leds: got %b expected 111", {led_r, led_g, led_b});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_blink();
    logic exp;
    sw_in = 2'b10;
    wait_edges(7);  // mode loads on edge 7 (edge M)
    checks++;
    if (mode !== MODE_BLINK) begin
      errors++; $display("FAIL blink_mode: got %b expected 10", mode);
    end
    // After edge M+1+i the LED shows phase (i/8)%2; switch back to SOLID
    // after M+16 so the mode changes at M+23, inside a low phase.
    for (int i = 0; i < 23; i++) begin
      wait_edges(1);
      exp = ((i / 8) % 2) == 1;
      checks++;
      if ({led_r, led_g, led_b} !== {3{exp}}) begin
        errors++; $display("FAIL blink_led_%0d: got %b expected %b", i, {led_r, led_g, led_b}, {3{exp}});
      end
      if (i == 15) sw_in = 2'b01;
    end
    checks++;
    if (mode !== MODE_SOLID) begin
      errors++; $display("FAIL blink_to_solid_mode: got %b expected 01", mode);
    end
    wait_edges(1);
    checks++;
    if ({led_r, led_g, led_b} !== 3'b111) begin
      errors++; $display("FAIL blink_to_solid_led: got %b expected 111", {led_r, led_g, led_b});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_off();
    sw_in = 2'b00;
    wait_edges(7);
    checks++;
    if (mode !== MODE_OFF) begin
      errors++; $display("FAIL off_mode: got %b expected 00", mode);
    end
    wait_edges(1);
    checks++;
    if ({led_r, led_g, led_b} !== 3'b000) begin
      errors++; $display("FAIL off_leds: got %b expected 000", {led_r, led_g, led_b});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_breathe();
    int m;
    int k;
    int p;
    int e_p;
    int exp_d;
    int duty_bad;
    int first_k;
    int first_got;
    int rgb_bad;
    int hi_cnt [16];
    foreach (hi_cnt[i]) hi_cnt[i] = 0;
    duty_bad = 0; first_k = -1; first_got = 0; rgb_bad = 0;

    sw_in = 2'b11;
    wait_edges(7);
    checks++;
    if (mode !== MODE_BREATHE) begin
      errors++; $display("FAIL breathe_mode: got %b expected 11", mode);
    end
    m = cyc;

    for (int it = 0; it < 1300; it++) begin
      wait_edges(1);
      k = cyc - m;
      if (k <= 1021) begin
        exp_d = duty_model(k / 2);
        if (int'(dut.r_duty) != exp_d) begin
          duty_bad++;
          if (first_k < 0) begin first_k = k; first_got = int'(dut.r_duty); end
        end
      end
      if (!(led_r == led_g && led_g == led_b)) rgb_bad++;
      // LED sample after edge c belongs to PWM period window p.
      p = (cyc - 1) / 256 - 1;
      if (p >= 0 && p < 16 && led_r === 1'b1) hi_cnt[p]++;
      if (p >= 0 && p < 16 && (cyc % 256) == 0) begin
        e_p = 256 * p + 255;  // edge after which duty is latched for window p
        if (e_p >= m && (e_p - m) <= 1021) begin
          exp_d = duty_model((e_p - m) / 2);
          checks++;
          if (hi_cnt[p] != exp_d) begin
            errors++; $display("FAIL breathe_pwm_win%0d: got %0d high cycles expected %0d", p, hi_cnt[p], exp_d);
          end
        end
      end
    end
    checks++;
    if (duty_bad != 0) begin
      errors++; $display("FAIL breathe_duty: %0d bad cycles, first at k=%0d got %0d expected %0d", duty_bad, first_k, first_got, duty_model(first_k / 2));
    end
    checks++;
    if (rgb_bad != 0) begin
      errors++; $display("FAIL breathe_rgb_equal: got %0d unequal cycles expected 0", rgb_bad);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_breathe();
    bit found = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (dut.r_duty == 8'd100) begin
        found = 1'b1;
        break;
      end
      wait_edges(1);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rst_mid_wait: got no duty=100 within 1500 cycles expected one");
    end
    rst = 1'b1;
    wait_edges(1);
    checks++;
    if (dut.r_duty !== 8'd0) begin
      errors++; $display("FAIL rst_mid_duty: got %0d expected 0", dut.r_duty);
    end
    checks++;
    if (dut.r_dir_down !== 1'b0) begin
      errors++; $display("FAIL rst_mid_dir: got down=%b expected 0", dut.r_dir_down);
    end
    checks++;
    if ({led_r, led_g, led_b} !== 3'b000 || mode !== MODE_OFF || sw_db !== 2'b00) begin
      errors++; $display("FAIL rst_mid_outputs: got leds=%b mode=%b sw_db=%b expected 000 00 00", {led_r, led_g, led_b}, mode, sw_db);
    end
    rst = 1'b0;
    wait_edges(5);
    checks++;
    if (sw_db !== 2'b00) begin
      errors++; $display("FAIL rst_mid_db_edge5: got %b expected 00", sw_db);
    end
    wait_edges(1);
    checks++;
    if (sw_db !== 2'b11) begin
      errors++; $display("FAIL rst_mid_db_edge6: got %b expected 11", sw_db);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst   = 1'b1;
    sw_in = 2'b00;
    test_reset();
    test_debounce();
    test_solid();
    test_blink();
    test_off();
    test_breathe();
    test_reset_mid_breathe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_led_ctrl.md
SW_LED_CTRL -- requirements
Module: sw_led_ctrl

Interface
- REQ-001: Parameter DB_LIMIT, default 1_000_000, sets the debounce stability window in clk100 cycles (10 ms at 100 MHz); legal range is >= 2.
- REQ-002: Parameter BLINK_HALF, default 50_000_000, sets the blink half-period in cycles; legal range is >= 2.
- REQ-003: Parameter BREATHE_STEP, default 390_625, sets the number of cycles per breathe duty step; legal range is >= 1.
- REQ-004: Port clk100, input, 1 bit, the single clock; all logic SHALL be in this domain.
- REQ-005: Port rst, input, 1 bit, synchronous active-high reset.
- REQ-006: Port sw_in, input, 2 bits, raw asynchronous GPIO switches.
- REQ-007: Ports led_r, led_g, led_b, outputs, 1 bit each, registered RGB LED drives.
- REQ-008: Port sw_db, output, 2 bits, debounced switch state.
- REQ-009: Port mode, output, 2 bits, current mode (mode_t).

Function
- REQ-010: Each sw_in bit SHALL pass through a 2-flop synchronizer before any other use.
- REQ-011: Each bit SHALL have a debounce counter sized by $clog2(DB_LIMIT).
  - Counter clears when synced value == sw_db, otherwise increments.
  - When the counter is at DB_LIMIT-1 with a mismatch, sw_db bit <= synced value and the counter clears.
- REQ-012: For a stable sw_in change, sw_db SHALL change on exactly the (DB_LIMIT+2)th rising edge after the change.
- REQ-013: A pulse on sw_in stable for fewer than DB_LIMIT synced cycles SHALL not change sw_db.
- REQ-014: mode SHALL equal sw_db registered one cycle: 00 OFF, 01 SOLID, 10 BLINK, 11 BREATHE.
  - Any mode-to-mode transition is legal.
- REQ-015: On any change of mode, the blink counter, blink phase, breathe step counter, duty, and direction SHALL clear.
  - Duty and direction clear to 0 and up respectively.
- REQ-016: OFF SHALL drive all LEDs 0; SOLID SHALL drive all LEDs 1.
- REQ-017: BLINK
  - The counter runs 0..BLINK_HALF-1; at terminal count the phase toggles and the counter wraps.
  - LEDs = phase, starting at 0 on mode entry.
- REQ-018: PWM
  - An 8-bit free-running pwm_cnt wraps 255->0.
  - pwm = (pwm_cnt < duty_active), where duty_active is an 8-bit shadow loaded from duty only when pwm_cnt == 255.
  - Duty 0 gives constant 0; duty 255 gives 255/256 high.
- REQ-019: BREATHE duty stepping
  - The step counter runs 0..BREATHE_STEP-1; at terminal count duty moves +1 (up) or -1 (down).
  - At duty 255 going up, direction flips to down and the next step gives 254.
  - At duty 0 going down, direction flips to up.
  - Duty SHALL never wrap.
- REQ-020: In BREATHE, led_r = led_g = led_b = pwm.
- REQ-021: LED outputs SHALL be registered, one cycle after the mode/phase/pwm value that produces them.

Reset
- REQ-022: While rst is high at a clk100 edge, the following SHALL clear to 0:
  - synchronizer flops, debounce counters, sw_db;
  - mode (OFF);
  - blink counter and phase, pwm_cnt, duty, duty_active, step counter;
  - LEDs.
  - Direction SHALL be set to up.
- REQ-023: Reset asserted mid-operation (e.g. mid-debounce or mid-breathe) SHALL discard all progress.
  - After release, a held switch SHALL reappear on sw_db after DB_LIMIT+2 edges.

Structure
- REQ-024: Package sw_led_pkg SHALL hold:
  - typedef mode_t (MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_BREATHE);
  - localparam PWM_W = 8.
- REQ-025: A single-bit sub-module sw_debounce (synchronizer plus counter, parameter DB_LIMIT) SHALL be instantiated twice.
- REQ-026: Mode, blink, breathe and PWM logic SHALL reside in sw_led_ctrl.

Verification (DB_LIMIT=4, BLINK_HALF=8, BREATHE_STEP=2)
- REQ-027: Reset: hold rst 3 cycles with sw_in=11 -> all outputs 0, mode=00; sw_db=11 on the 6th edge after release.
- REQ-028: Debounce: sw_in 00->01 stable -> sw_db=01 exactly 6 edges later; a 3-cycle glitch to 10 -> sw_db unchanged.
- REQ-029: BLINK: sw_db=10 -> LEDs 0 for 8 cycles, then 1 for 8, repeating; switching to SOLID mid-phase -> LEDs 1 one cycle after mode changes.
- REQ-030: BREATHE: duty ramps to 255 then 254; it never shows 0 after 255 or 255 after 0; the LED high-count per 256-cycle PWM period equals the duty latched at the prior pwm_cnt==255.
- REQ-031: Reset mid-BREATHE at duty=100 -> duty 0, direction up, LEDs 0 the next cycle.
